// File: rtl/mmio_read_unit.sv
// Load-side address decoder: returns BRAM data or synchronized board inputs,
// plus a sticky change-status word, with a fixed one-cycle read latency.
module mmio_read_unit #(
   parameter int addr_width  = 10,
   parameter int data_width  = 32,
   parameter int sync_stages = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [addr_width-1:0] addr,
   input  logic [data_width-1:0] mem_rdata,
   input  logic [data_width-1:0] in_port0,
   input  logic [data_width-1:0] in_port1,
   output logic [data_width-1:0] rdata,
   output logic                  rvalid,
   output logic [4:0]            sel_mux_data_out
);

   typedef enum logic [4:0] {
      SEL_MEM  = 5'd0,
      SEL_P0   = 5'd1,
      SEL_P1   = 5'd2,
      SEL_STAT = 5'd3
   } sel_e;

   localparam logic [addr_width-1:0] A_P0   = {addr_width{1'b1}};
   localparam logic [addr_width-1:0] A_P1   = A_P0 - addr_width'(1);
   localparam logic [addr_width-1:0] A_STAT = A_P0 - addr_width'(2);

   logic [data_width-1:0] s0_q [sync_stages];
   logic [data_width-1:0] s1_q [sync_stages];
   logic [data_width-1:0] sync0;
   logic [data_width-1:0] sync1;
   logic [data_width-1:0] prev0_q;
   logic [data_width-1:0] prev1_q;
   logic [data_width-1:0] cap_q;
   logic [data_width-1:0] cap_d;
   logic [data_width-1:0] stat_w;
   logic                  chg0_q;
   logic                  chg1_q;
   logic                  det0;
   logic                  det1;
   logic                  accept;
   logic                  clr;
   logic                  rvalid_q;
   sel_e                  sel_q;
   sel_e                  sel_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < sync_stages; i++) begin
            s0_q[i] <= '0;
            s1_q[i] <= '0;
         end
      end else begin
         s0_q[0] <= in_port0;
         s1_q[0] <= in_port1;
         for (int i = 1; i < sync_stages; i++) begin
            s0_q[i] <= s0_q[i-1];
            s1_q[i] <= s1_q[i-1];
         end
      end
   end

   assign sync0  = s0_q[sync_stages-1];
   assign sync1  = s1_q[sync_stages-1];
   assign det0   = (sync0 != prev0_q);
   assign det1   = (sync1 != prev1_q);
   assign accept = rd_en & ~wr_en;
   assign stat_w = {{(data_width-2){1'b0}}, chg1_q, chg0_q};

   always_comb begin
      sel_d = SEL_MEM;
      cap_d = cap_q;
      clr   = 1'b0;
      unique case (1'b1)
         (accept && addr == A_P0): begin
            sel_d = SEL_P0;
            cap_d = sync0;
         end
         (accept && addr == A_P1): begin
            sel_d = SEL_P1;
            cap_d = sync1;
         end
         (accept && addr == A_STAT): begin
            sel_d = SEL_STAT;
            cap_d = stat_w;
            clr   = 1'b1;
         end
         default: ;
      endcase
   end

   // a change seen in the clearing cycle survives the clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev0_q  <= '0;
         prev1_q  <= '0;
         chg0_q   <= 1'b0;
         chg1_q   <= 1'b0;
         cap_q    <= '0;
         rvalid_q <= 1'b0;
         sel_q    <= SEL_MEM;
      end else begin
         prev0_q  <= sync0;
         prev1_q  <= sync1;
         chg0_q   <= det0 | (chg0_q & ~clr);
         chg1_q   <= det1 | (chg1_q & ~clr);
         cap_q    <= cap_d;
         rvalid_q <= accept;
         sel_q    <= sel_d;
      end
   end

   assign rvalid           = rvalid_q;
   assign sel_mux_data_out = sel_q;

   always_comb begin
      rdata = '0;
      if (rvalid_q) begin
         rdata = (sel_q == SEL_MEM) ? mem_rdata : cap_q;
      end
   end

endmodule

// File: tb/tb_mmio_read_unit.sv
// Scoreboard bench for mmio_read_unit: a reference model predicts each load
// result at issue time, a negedge monitor checks what the design returns.
module tb_mmio_read_unit;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd_en = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] in_port0 = '0;
   logic [DW-1:0] in_port1 = '0;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic [4:0]    sel;

   mmio_read_unit #(
      .addr_width (AW),
      .data_width (DW),
      .sync_stages(S)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rd_en           (rd_en),
      .wr_en           (wr_en),
      .addr            (addr),
      .mem_rdata       (mem_rdata),
      .in_port0        (in_port0),
      .in_port1        (in_port1),
      .rdata           (rdata),
      .rvalid          (rvalid),
      .sel_mux_data_out(sel)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic [4:0]  sel;
   } exp_t;

   exp_t          sbq[$];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;

   // model state: input history per clock edge, sticky flags, BRAM image
   logic [DW-1:0] h0 [S+1];
   logic [DW-1:0] h1 [S+1];
   logic          f0;
   logic          f1;
   logic [DW-1:0] mem [1024];
   logic          last_mem;
   logic [AW-1:0] last_addr;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_clear();
      for (int i = 0; i <= S; i++) begin
         h0[i] = '0;
         h1[i] = '0;
      end
      f0 = 1'b0;
      f1 = 1'b0;
      last_mem = 1'b0;
      last_addr = '0;
   endtask

   // called just after a rising edge; sets inputs for the next edge
   task automatic drive(input logic r, input logic w, input logic [AW-1:0] a);
      logic [DW-1:0] s0, s1;
      logic          d0, d1;
      logic          acc;
      mem_rdata = last_mem ? mem[last_addr] : DW'($urandom);
      rd_en = r;
      wr_en = w;
      addr  = a;
      s0 = h0[S-1];
      s1 = h1[S-1];
      d0 = (h0[S-1] != h0[S]);
      d1 = (h1[S-1] != h1[S]);
      acc = r && !w;
      last_mem = 1'b0;
      if (acc) begin
         if (a == 10'h3FF)
            sbq.push_back('{due: cyc + 1, data: s0, sel: 5'd1});
         else if (a == 10'h3FE)
            sbq.push_back('{due: cyc + 1, data: s1, sel: 5'd2});
         else if (a == 10'h3FD)
            sbq.push_back('{due: cyc + 1, data: {30'd0, f1, f0}, sel: 5'd3});
         else begin
            sbq.push_back('{due: cyc + 1, data: mem[a], sel: 5'd0});
            last_mem = 1'b1;
            last_addr = a;
         end
      end
      if (acc && a == 10'h3FD) begin
         f0 = d0;
         f1 = d1;
      end else begin
         f0 = f0 | d0;
         f1 = f1 | d1;
      end
      for (int i = S; i > 0; i--) begin
         h0[i] = h0[i-1];
         h1[i] = h1[i-1];
      end
      h0[0] = in_port0;
      h1[0] = in_port1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, AW'($urandom));
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      rd_en = 1'b1;
      wr_en = 1'b0;
      addr  = 10'h3FD;
      #1;
      total++;
      if (rvalid !== 1'b0 || rdata !== '0 || sel !== 5'd0) begin
         bad++;
         $display("FAIL reset_out: rvalid=%b rdata=%h sel=%0d want 0/0/0",
                  rvalid, rdata, sel);
      end
      sbq.delete();
      model_clear();
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd_en = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rvalid) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL extra_rvalid: cyc=%0d rdata=%h sel=%0d want none",
                     cyc, rdata, sel);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if (e.due != cyc || rdata !== e.data || sel !== e.sel) begin
               bad++;
               $display("FAIL read: cyc=%0d got %h sel=%0d want %h sel=%0d due=%0d",
                        cyc, rdata, sel, e.data, e.sel, e.due);
            end
         end
      end else begin
         total++;
         if (rdata !== '0 || sel !== 5'd0) begin
            bad++;
            $display("FAIL idle_out: cyc=%0d rdata=%h sel=%0d want 0/0",
                     cyc, rdata, sel);
         end
         if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL missing_rvalid: cyc=%0d got none want %h sel=%0d",
                     cyc, e.data, e.sel);
         end
      end
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[16] = 32'hDEADBEEF;
      model_clear();
      @(posedge clk);
      #1;
      do_reset(3);

      drive(1'b1, 1'b0, 10'h010);
      idle(2);

      in_port0 = 32'h0000_00A5;
      idle(4);
      drive(1'b1, 1'b0, 10'h3FF);
      in_port1 = 32'h0000_1234;
      idle(4);
      drive(1'b1, 1'b0, 10'h3FE);
      idle(1);

      drive(1'b1, 1'b0, 10'h3FD);
      drive(1'b1, 1'b0, 10'h3FD);
      in_port1 = ~in_port1;
      idle(3);
      drive(1'b1, 1'b0, 10'h3FD);
      drive(1'b1, 1'b0, 10'h3FD);
      in_port1 = ~in_port1;
      idle(1);
      drive(1'b1, 1'b0, 10'h3FD);
      drive(1'b1, 1'b0, 10'h3FD);
      idle(1);

      in_port0 = 32'h0000_005A;
      idle(3);
      drive(1'b1, 1'b1, 10'h3FD);
      idle(1);
      drive(1'b1, 1'b0, 10'h3FD);
      idle(1);

      drive(1'b1, 1'b0, 10'h3FF);
      drive(1'b1, 1'b0, 10'h020);
      drive(1'b1, 1'b0, 10'h3FE);
      idle(1);
      drive(1'b1, 1'b0, 10'h3FF);
      do_reset(2);
      idle(1);

      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] a;
         if ($urandom_range(0, 7) == 0) in_port0 = $urandom;
         if ($urandom_range(0, 7) == 0) in_port1 = $urandom;
         case ($urandom_range(0, 5))
            0: a = 10'h3FF;
            1: a = 10'h3FE;
            2: a = 10'h3FD;
            3: a = 10'h3FC;
            default: a = AW'($urandom);
         endcase
         if ($urandom_range(0, 99) == 0)
            do_reset($urandom_range(1, 3));
         else
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, a);
      end

      idle(4);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
